// File: rtl/voice_pkg.sv
// Shared constants for the voice scheduler block.
//   NOTE_W / HZ_W   : note index and frequency word widths of the synthesizer lookup
//   NOTE_MIN/MAX    : legal note range
//   StIdle/StApply  : scheduler FSM encodings
//   note_legal()    : range check used on incoming note-on events
package voice_pkg;

  localparam int unsigned NOTE_W   = 8;
  localparam int unsigned HZ_W     = 14;
  localparam int unsigned NOTE_MIN = 1;
  localparam int unsigned NOTE_MAX = 88;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StApply = 1'b1;

  function automatic logic note_legal(input logic [NOTE_W-1:0] note,
                                      input int unsigned note_max);
    return (32'(note) >= NOTE_MIN) && (32'(note) <= note_max);
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Bundle of the voice scheduler's event, lookup and voice-output signals.
//   ev_valid/ev_ready/ev_on/ev_note : key event handshake
//   syn_note / syn_hz               : synthesizer lookup request and registered result
//   voice_active / voice_hz         : per-voice state presented to tone generators
//   ev_dropped                      : pulse when an accepted event is discarded
// Modports: slave = scheduler side, master = event source / synthesizer side.
interface voice_scheduler_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned HZ_W       = 14
);
  import voice_pkg::*;

  logic                       ev_valid;
  logic                       ev_ready;
  logic                       ev_on;
  logic [NOTE_W-1:0]          ev_note;
  logic [NOTE_W-1:0]          syn_note;
  logic [HZ_W-1:0]            syn_hz;
  logic [NUM_VOICES-1:0]      voice_active;
  logic [NUM_VOICES*HZ_W-1:0] voice_hz;
  logic                       ev_dropped;

  modport slave (
    input  ev_valid, ev_on, ev_note, syn_hz,
    output ev_ready, syn_note, voice_active, voice_hz, ev_dropped
  );

  modport master (
    output ev_valid, ev_on, ev_note, syn_hz,
    input  ev_ready, syn_note, voice_active, voice_hz, ev_dropped
  );

endinterface

// File: rtl/voice_pick.sv
// Combinational voice table search.
//   notes/active/ages : packed per-voice table
//   search            : note being looked up
//   match_hit/idx     : lowest active voice holding search
//   free_hit/idx      : lowest inactive voice
//   oldest_idx        : voice with the largest age, ties to the lowest index
module voice_pick
  import voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned AGE_W      = 2
) (
  input  logic [NUM_VOICES*NOTE_W-1:0] notes,
  input  logic [NUM_VOICES-1:0]        active,
  input  logic [NUM_VOICES*AGE_W-1:0]  ages,
  input  logic [NOTE_W-1:0]            search,
  output logic                         match_hit,
  output logic [IDX_W-1:0]             match_idx,
  output logic                         free_hit,
  output logic [IDX_W-1:0]             free_idx,
  output logic [IDX_W-1:0]             oldest_idx
);

  logic [AGE_W-1:0] oldest_age;

  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    oldest_age = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!match_hit && active[v] && (notes[v*NOTE_W +: NOTE_W] == search)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(v);
      end
      if (!free_hit && !active[v]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(v);
      end
      // Strict compare keeps the lowest index on ties.
      if (ages[v*AGE_W +: AGE_W] > oldest_age) begin
        oldest_age = ages[v*AGE_W +: AGE_W];
        oldest_idx = IDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator and synthesizer lookup scheduler.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : voice_scheduler_if.slave (event handshake, lookup port, voice outputs)
// Events are accepted in IDLE and decided in the following APPLY cycle. The single lookup
// port is given to the event in APPLY; every other cycle refreshes voice ptr round-robin.
// Lookup results are captured one cycle later only if the voice still holds the issued note.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all voices are busy;
// otherwise such a note-on is dropped.
module voice_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_MAX   = voice_pkg::NOTE_MAX,
  parameter int unsigned HZ_W       = voice_pkg::HZ_W
) (
  input logic              clk,
  input logic              reset,
  voice_scheduler_if.slave bus
);
  import voice_pkg::*;

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned AGE_W = IDX_W;
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_VOICES - 1);

  logic [0:0]                 state_q, state_d;
  logic                       ev_on_q;
  logic [NOTE_W-1:0]          ev_note_q;
  logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0]      active_q, active_d;
  logic [NUM_VOICES*AGE_W-1:0] age_q, age_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic                       issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]           issue_idx_q, issue_idx_d;
  logic [NOTE_W-1:0]          issue_note_q, issue_note_d;
  logic [NUM_VOICES*HZ_W-1:0] hz_q, hz_d;

  logic             is_apply;
  logic             accept;
  logic             alloc;
  logic [IDX_W-1:0] alloc_idx;
  logic             rel_en;
  logic [IDX_W-1:0] rel_idx;
  logic             drop;
  logic             cap_ok;

  logic             match_hit, free_hit;
  logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;

  voice_pick #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W),
    .AGE_W      (AGE_W)
  ) u_pick (
    .notes      (note_q),
    .active     (active_q),
    .ages       (age_q),
    .search     (ev_note_q),
    .match_hit  (match_hit),
    .match_idx  (match_idx),
    .free_hit   (free_hit),
    .free_idx   (free_idx),
    .oldest_idx (oldest_idx)
  );

  assign is_apply = (state_q == StApply);
  assign accept   = bus.ev_valid && bus.ev_ready;

  // Event decision, only meaningful in APPLY.
  always_comb begin
    alloc     = 1'b0;
    alloc_idx = '0;
    rel_en    = 1'b0;
    rel_idx   = '0;
    drop      = 1'b0;
    if (is_apply) begin
      if (ev_on_q) begin
        if (!note_legal(ev_note_q, NOTE_MAX)) begin
          drop = 1'b1;
        end else if (match_hit) begin
          alloc     = 1'b1;
          alloc_idx = match_idx;
        end else if (free_hit) begin
          alloc     = 1'b1;
          alloc_idx = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          alloc     = 1'b1;
          alloc_idx = oldest_idx;
`else
          drop      = 1'b1;
`endif
        end
      end else if (match_hit) begin
        rel_en  = 1'b1;
        rel_idx = match_idx;
      end
    end
  end

  // Voice table update.
  always_comb begin
    note_d   = note_q;
    active_d = active_q;
    age_d    = age_q;
    if (alloc) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (IDX_W'(v) == alloc_idx) begin
          note_d[v*NOTE_W +: NOTE_W] = ev_note_q;
          active_d[v]                = 1'b1;
          age_d[v*AGE_W +: AGE_W]    = '0;
        end else if (active_q[v] && (age_q[v*AGE_W +: AGE_W] < AGE_SAT)) begin
          age_d[v*AGE_W +: AGE_W] = age_q[v*AGE_W +: AGE_W] + 1'b1;
        end
      end
    end
    if (rel_en) begin
      active_d[rel_idx] = 1'b0;
    end
  end

  // Lookup port arbitration: the event owns APPLY, refresh owns every other cycle.
  always_comb begin
    issue_valid_d = 1'b0;
    issue_idx_d   = ptr_q;
    issue_note_d  = '0;
    if (alloc) begin
      issue_valid_d = 1'b1;
      issue_idx_d   = alloc_idx;
      issue_note_d  = ev_note_q;
    end else if (!is_apply && active_q[ptr_q]) begin
      issue_valid_d = 1'b1;
      issue_note_d  = note_q[int'(ptr_q)*NOTE_W +: NOTE_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (!is_apply) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // A result lands only on a voice that still holds the note it was issued for.
  assign cap_ok = issue_valid_q && active_q[issue_idx_q] &&
                  (note_q[int'(issue_idx_q)*NOTE_W +: NOTE_W] == issue_note_q);

  always_comb begin
    hz_d = hz_q;
    if (cap_ok) begin
      hz_d[int'(issue_idx_q)*HZ_W +: HZ_W] = bus.syn_hz;
    end
    // Release wins over a capture landing in the same cycle.
    if (rel_en) begin
      hz_d[int'(rel_idx)*HZ_W +: HZ_W] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (is_apply) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = StApply;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      note_q        <= '0;
      active_q      <= '0;
      age_q         <= '0;
      ptr_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      issue_note_q  <= '0;
      hz_q          <= '0;
    end else begin
      state_q       <= state_d;
      if (accept) begin
        ev_on_q   <= bus.ev_on;
        ev_note_q <= bus.ev_note;
      end
      note_q        <= note_d;
      active_q      <= active_d;
      age_q         <= age_d;
      ptr_q         <= ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      issue_note_q  <= issue_note_d;
      hz_q          <= hz_d;
    end
  end

  assign bus.ev_ready     = !reset && (state_q == StIdle);
  assign bus.syn_note     = reset ? '0 : issue_note_d;
  assign bus.ev_dropped   = !reset && drop;
  assign bus.voice_active = active_q;
  assign bus.voice_hz     = hz_q;

endmodule
